imm_gen_stage: RTL and testbench

Registered, parametrised immediate-generation stage for the RISC-V decode path. It accepts one instruction per cycle over a valid/ready handshake. It decodes the immediate, sign- or zero-extended to XLEN, and reports its format code and an illegal-opcode flag. Results leave through a one-deep output register backed by a one-entry skid buffer, so the stage sustains full throughput under downstream back-pressure. It sits between fetch/instruction-buffer and the register-read stage, and carries an opaque tag (typically the PC) alongside each result.

---
 rtl/imm_gen_stage_pkg.sv | 36 +++
 rtl/imm_gen_stage_if.sv | 30 +++
 rtl/imm_gen_stage_decode.sv | 83 ++++++++
 rtl/imm_gen_stage.sv | 105 ++++++++++
 tb/tb_imm_gen_stage.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imm_gen_stage_pkg.sv
// Shared opcode, funct3 and format-code definitions for the immediate-generation stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imm_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPIMM32   = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] SYSTEM    = 7'b1110011;

   // funct3 values that turn OP-IMM / OP-IMM-32 into shifts (imm is a shamt)
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } fmt_t;

   // 12-bit field sign-extended to 32 bits
   function automatic logic [31:0] sext12(input logic [11:0] v);
      return {{20{v[11]}}, v};
   endfunction

endpackage

// File: rtl/imm_gen_stage_if.sv
// Instruction-in / immediate-out handshake bundle for imm_gen_stage.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the input and the output side.
interface imm_gen_stage_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [2:0]       out_fmt;
   logic             out_illegal;
   logic [TAG_W-1:0] out_tag;

   // environment side: produces instructions, consumes results
   modport master (
      output in_valid, in_instr, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
   );

   // stage side
   modport slave (
      input  in_valid, in_instr, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
   );
endinterface

// File: rtl/imm_gen_stage_decode.sv
// Combinational RISC-V immediate decoder; SYSTEM/CSR-immediate support when IMM_ZICSR_EN is defined.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows instr.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output fmt_t            fmt,
   output logic            illegal
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_shift;
   logic [31:0] imm32;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SRX);

   // Build the immediate as a 32-bit value; every format is either sign-extended
   // from bit 31 or a small non-negative field, so one final sign-extension to XLEN covers all.
   always_comb begin
      imm32   = '0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      case (opcode)
         OP_LOAD, OP_JALR: begin
            fmt   = FMT_I;
            imm32 = sext12(instr[31:20]);
         end
         OP_OPIMM: begin
            fmt = FMT_I;
            if (is_shift) begin
               imm32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
            end else begin
               imm32 = sext12(instr[31:20]);
            end
         end
         OPIMM32: begin
            if (XLEN == 64) begin
               fmt   = FMT_I;
               imm32 = is_shift ? {27'b0, instr[24:20]} : sext12(instr[31:20]);
            end else begin
               illegal = 1'b1;
            end
         end
         OP_STORE: begin
            fmt   = FMT_S;
            imm32 = sext12({instr[31:25], instr[11:7]});
         end
         OP_BRANCH: begin
            fmt   = FMT_B;
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_JAL: begin
            fmt   = FMT_J;
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            fmt   = FMT_U;
            imm32 = {instr[31:12], 12'b0};
         end
         SYSTEM: begin
`ifdef IMM_ZICSR_EN
            if (funct3[2]) begin
               fmt   = FMT_Z;
               imm32 = {27'b0, instr[19:15]};
            end
`endif
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

   assign imm = XLEN'(signed'(imm32));

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage: imm_decode behind an output register plus one-entry skid (optional IMM_ZICSR_EN).
// Latency: 1 cycle from input transfer to out_valid when the output register is free.
// Backpressure: full rate under out_ready; in_ready (registered) drops only while the skid entry holds data.
module imm_gen_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input logic            clk,
   input logic            rst,
   imm_gen_stage_if.slave bus
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      fmt_t             fmt;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } res_t;

   logic [XLEN-1:0] dec_imm;
   fmt_t            dec_fmt;
   logic            dec_illegal;
   res_t            new_dat;

   logic or_vld_q, or_vld_d;
   logic sk_vld_q, sk_vld_d;
   logic in_rdy_q, in_rdy_d;
   res_t or_dat_q, or_dat_d;
   res_t sk_dat_q, sk_dat_d;

   logic acc;
   logic drain;

   imm_decode #(.XLEN(XLEN)) u_dec (
      .instr   (bus.in_instr),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_illegal)
   );

   // Pack the freshly decoded result together with its tag
   always_comb begin
      new_dat         = '0;
      new_dat.imm     = dec_imm;
      new_dat.fmt     = dec_fmt;
      new_dat.illegal = dec_illegal;
      new_dat.tag     = bus.in_tag;
   end

   assign acc   = bus.in_valid && in_rdy_q;
   assign drain = or_vld_q && bus.out_ready;

   // Output register / skid steering; skid always refills the output register first
   always_comb begin
      or_vld_d = or_vld_q;
      or_dat_d = or_dat_q;
      sk_vld_d = sk_vld_q;
      sk_dat_d = sk_dat_q;
      if (sk_vld_q) begin
         // in_ready is low here, so no accept can collide with the refill
         if (drain) begin
            or_dat_d = sk_dat_q;
            sk_vld_d = 1'b0;
         end
      end else if (acc) begin
         if (!or_vld_q || drain) begin
            or_vld_d = 1'b1;
            or_dat_d = new_dat;
         end else begin
            sk_vld_d = 1'b1;
            sk_dat_d = new_dat;
         end
      end else if (drain) begin
         or_vld_d = 1'b0;
      end
      in_rdy_d = !sk_vld_d;
   end

   // State registers with synchronous reset; reset clears data so outputs read zero
   always_ff @(posedge clk) begin
      if (rst) begin
         or_vld_q <= 1'b0;
         sk_vld_q <= 1'b0;
         in_rdy_q <= 1'b1;
         or_dat_q <= '0;
         sk_dat_q <= '0;
      end else begin
         or_vld_q <= or_vld_d;
         sk_vld_q <= sk_vld_d;
         in_rdy_q <= in_rdy_d;
         or_dat_q <= or_dat_d;
         sk_dat_q <= sk_dat_d;
      end
   end

   assign bus.in_ready    = in_rdy_q;
   assign bus.out_valid   = or_vld_q;
   assign bus.out_imm     = or_dat_q.imm;
   assign bus.out_fmt     = or_dat_q.fmt;
   assign bus.out_illegal = or_dat_q.illegal;
   assign bus.out_tag     = or_dat_q.tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances driven with identical stimulus.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low and filling the skid entry.
module tb_imm_gen_stage;

   logic clk;
   logic rst;

   imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) if32 ();
   imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) if64 ();

   imm_gen_stage #(.XLEN(32), .TAG_W(32)) u32 (.clk(clk), .rst(rst), .bus(if32));
   imm_gen_stage #(.XLEN(64), .TAG_W(32)) u64 (.clk(clk), .rst(rst), .bus(if64));

   int n_chk = 0;
   int n_err = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] tag, input logic ordy);
      if32.in_valid  = v;  if64.in_valid  = v;
      if32.in_instr  = ins; if64.in_instr = ins;
      if32.in_tag    = tag; if64.in_tag   = tag;
      if32.out_ready = ordy; if64.out_ready = ordy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic longint sext(input longint val, input int bits);
      longint half;
      half = longint'(1) << (bits - 1);
      return (val >= half) ? val - (half * 2) : val;
   endfunction

   // Reference decoder: immediate value as a plain integer, then reduced to XLEN bits
   function automatic void model(input logic [31:0] ins, input int xlen,
                                 output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
      longint v;
      int op, f3;
      op  = int'(ins[6:0]);
      f3  = int'(ins[14:12]);
      v   = 0;
      fmt = 3'd0;
      ill = 1'b0;
      case (op)
         'h03, 'h67: begin fmt = 3'd1; v = sext(longint'(ins[31:20]), 12); end
         'h13: begin
            fmt = 3'd1;
            if (f3 == 1 || f3 == 5) v = (xlen == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
            else v = sext(longint'(ins[31:20]), 12);
         end
         'h1B: begin
            if (xlen == 64) begin
               fmt = 3'd1;
               if (f3 == 1 || f3 == 5) v = longint'(ins[24:20]);
               else v = sext(longint'(ins[31:20]), 12);
            end else ill = 1'b1;
         end
         'h23: begin fmt = 3'd2; v = sext(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); end
         'h63: begin
            fmt = 3'd3;
            v = sext(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                     longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
         end
         'h6F: begin
            fmt = 3'd5;
            v = sext(longint'(ins[31]) * (1 << 20) + longint'(ins[19:12]) * 4096 +
                     longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
         end
         'h37, 'h17: begin fmt = 3'd4; v = sext(longint'(ins[31:12]), 20) * 4096; end
         'h73: begin
`ifdef IMM_ZICSR_EN
            if (ins[14]) begin fmt = 3'd6; v = longint'(ins[19:15]); end
`endif
         end
         default: ill = 1'b1;
      endcase
      imm = 64'(v);
      if (xlen == 32) imm = {32'b0, imm[31:0]};
   endfunction

   // One isolated transfer followed by a full check of both instances one cycle later
   task automatic xact(input string nm, input logic [31:0] ins, input logic [31:0] tag,
                       input logic [63:0] e32, input logic [63:0] e64,
                       input logic [2:0] f32, input logic [2:0] f64,
                       input logic i32, input logic i64);
      drive(1'b1, ins, tag, 1'b1);
      chk({nm, ".in_ready"}, {63'b0, if32.in_ready & if64.in_ready}, 64'd1);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      chk({nm, ".vld32"}, {63'b0, if32.out_valid}, 64'd1);
      chk({nm, ".imm32"}, 64'(if32.out_imm), e32);
      chk({nm, ".fmt32"}, 64'(if32.out_fmt), 64'(f32));
      chk({nm, ".ill32"}, 64'(if32.out_illegal), 64'(i32));
      chk({nm, ".tag32"}, 64'(if32.out_tag), 64'(tag));
      chk({nm, ".vld64"}, {63'b0, if64.out_valid}, 64'd1);
      chk({nm, ".imm64"}, if64.out_imm, e64);
      chk({nm, ".fmt64"}, 64'(if64.out_fmt), 64'(f64));
      chk({nm, ".ill64"}, 64'(if64.out_illegal), 64'(i64));
      chk({nm, ".tag64"}, 64'(if64.out_tag), 64'(tag));
   endtask

   logic [6:0]  ops [12] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63,
                             7'h6F, 7'h37, 7'h17, 7'h73, 7'h7F, 7'h33};
   logic [31:0] rnd, rins, rtag, ntag;
   logic [63:0] m32, m64;
   logic [2:0]  mf32, mf64;
   logic        mi32, mi64;
   logic [31:0] got32 [$];
   logic [31:0] got64 [$];
   int          first_cyc, last_cyc, seen_cyc, vcount;
   logic [63:0] csr_imm;
   logic [2:0]  csr_fmt;

   initial begin
      drive(1'b0, 32'h0, 32'h0, 1'b1);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // reset state
      chk("rst.vld32", {63'b0, if32.out_valid}, 64'd0);
      chk("rst.rdy32", {63'b0, if32.in_ready}, 64'd1);
      chk("rst.imm32", 64'(if32.out_imm), 64'd0);
      chk("rst.fmt32", 64'(if32.out_fmt), 64'd0);
      chk("rst.ill32", 64'(if32.out_illegal), 64'd0);
      chk("rst.tag32", 64'(if32.out_tag), 64'd0);
      chk("rst.vld64", {63'b0, if64.out_valid}, 64'd0);
      chk("rst.rdy64", {63'b0, if64.in_ready}, 64'd1);

      // directed vectors with hand-derived expectations
      xact("addi",  32'hFFF00093, 32'h10, 64'h00000000FFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0);
      xact("srai",  32'h4030D093, 32'h11, 64'd3, 64'd3, 3'd1, 3'd1, 1'b0, 1'b0);
      xact("sw",    32'hFE112E23, 32'h12, 64'h00000000FFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, 3'd2, 1'b0, 1'b0);
      xact("lui",   32'h123452B7, 32'h13, 64'h12345000, 64'h12345000, 3'd4, 3'd4, 1'b0, 1'b0);
      xact("bad",   32'h0000007F, 32'h14, 64'd0, 64'd0, 3'd0, 3'd0, 1'b1, 1'b1);
      xact("luineg",32'h800002B7, 32'h15, 64'h0000000080000000, 64'hFFFFFFFF80000000, 3'd4, 3'd4, 1'b0, 1'b0);
      xact("slli33",32'h02109093, 32'h16, 64'd1, 64'd33, 3'd1, 3'd1, 1'b0, 1'b0);
      xact("addiw", 32'hFFF0009B, 32'h17, 64'd0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 3'd1, 1'b1, 1'b0);
      xact("ld",    32'h00000003, 32'h18, 64'd0, 64'd0, 3'd1, 3'd1, 1'b0, 1'b0);
`ifdef IMM_ZICSR_EN
      csr_imm = 64'd5;
      csr_fmt = 3'd6;
`else
      csr_imm = 64'd0;
      csr_fmt = 3'd0;
`endif
      xact("csrrwi",32'h3002D0F3, 32'h19, csr_imm, csr_imm, csr_fmt, csr_fmt, 1'b0, 1'b0);

      // randomized instructions against the reference model
      for (int k = 0; k < 150; k++) begin
         rnd  = $urandom();
         rtag = $urandom();
         if (k % 10 == 9) rins = rnd;
         else rins = {rnd[31:7], ops[$urandom_range(0, 11)]};
         model(rins, 32, m32, mf32, mi32);
         model(rins, 64, m64, mf64, mi64);
         xact("rand", rins, rtag, m32, m64, mf32, mf64, mi32, mi64);
      end

      // back-pressure: four back-to-back inputs while out_ready is low for three cycles
      step();
      drive(1'b1, 32'h00100093, 32'd1, 1'b0);
      chk("bp.rdy1", {63'b0, if32.in_ready}, 64'd1);
      step();
      drive(1'b1, 32'h00200093, 32'd2, 1'b0);
      chk("bp.rdy2", {63'b0, if32.in_ready}, 64'd1);
      step();
      drive(1'b1, 32'h00300093, 32'd3, 1'b0);
      chk("bp.full32", {63'b0, if32.in_ready}, 64'd0);
      chk("bp.full64", {63'b0, if64.in_ready}, 64'd0);
      step();
      chk("bp.hold", {63'b0, if32.in_ready}, 64'd0);
      chk("bp.head", 64'(if32.out_tag), 64'd1);
      if32.out_ready = 1'b1;
      if64.out_ready = 1'b1;
      ntag = 32'd3;
      first_cyc = -1;
      last_cyc  = -1;
      for (int c = 0; c < 20; c++) begin
         if (if32.out_valid) begin
            got32.push_back(if32.out_tag);
            if (first_cyc < 0) first_cyc = c;
            last_cyc = c;
         end
         if (if64.out_valid) got64.push_back(if64.out_tag);
         if (if32.in_valid && if32.in_ready) ntag = ntag + 1;
         step();
         if (ntag > 32'd4) drive(1'b0, 32'h0, 32'h0, 1'b1);
         else drive(1'b1, 32'h00000093 | (ntag << 20), ntag, 1'b1);
      end
      chk("bp.count32", 64'(got32.size()), 64'd4);
      chk("bp.count64", 64'(got64.size()), 64'd4);
      seen_cyc = last_cyc - first_cyc;
      chk("bp.consec", 64'(seen_cyc), 64'd3);
      for (int i = 0; i < 4; i++) begin
         chk("bp.order32", (i < got32.size()) ? 64'(got32[i]) : 64'hDEAD, 64'(i + 1));
         chk("bp.order64", (i < got64.size()) ? 64'(got64[i]) : 64'hDEAD, 64'(i + 1));
      end

      // reset while both the output register and the skid entry hold data
      drive(1'b1, 32'h00500093, 32'd77, 1'b0);
      step();
      drive(1'b1, 32'h00600093, 32'd78, 1'b0);
      step();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      chk("rf.full", {63'b0, if32.in_ready}, 64'd0);
      chk("rf.vld", {63'b0, if32.out_valid}, 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rf.vld32", {63'b0, if32.out_valid}, 64'd0);
      chk("rf.rdy32", {63'b0, if32.in_ready}, 64'd1);
      chk("rf.imm32", 64'(if32.out_imm), 64'd0);
      chk("rf.tag32", 64'(if32.out_tag), 64'd0);
      chk("rf.vld64", {63'b0, if64.out_valid}, 64'd0);
      chk("rf.rdy64", {63'b0, if64.in_ready}, 64'd1);
      chk("rf.imm64", if64.out_imm, 64'd0);
      chk("rf.fmt64", 64'(if64.out_fmt), 64'd0);
      if32.out_ready = 1'b1;
      if64.out_ready = 1'b1;
      vcount = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (if32.out_valid || if64.out_valid) vcount++;
      end
      chk("rf.stale", 64'(vcount), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
